// File: rtl/pipe_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined ripple-carry adder.
// Optional signed-overflow output is enabled by defining PIPE_ADDER_OVF_EN.
package pipe_adder_pkg;

    localparam int PA_WIDTH_DEF  = 8;
    localparam int PA_STAGES_DEF = 2;

    function automatic bit pa_cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Operand bits still pending at stage k are packed back to back: stage k keeps (stages-k) slices.
    function automatic int pa_op_off(input int k, input int stages, input int sw);
        return sw * ((k * stages) - ((k * (k - 1)) / 2));
    endfunction

    // Stage k (1..stages) keeps k finished sum slices; offsets of that triangle.
    function automatic int pa_sum_off(input int k, input int sw);
        return sw * ((k * (k - 1)) / 2);
    endfunction

    // One full adder: returns {carry_out, sum}.
    function automatic logic [1:0] pa_full_add(input logic x, input logic y, input logic ci);
        logic w_p;
        w_p = x ^ y;
        return {(x & y) | (w_p & ci), w_p ^ ci};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SW-bit ripple-carry adder slice built from full adders.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic [SW-1:0] i_a,
    input  logic [SW-1:0] i_b,
    input  logic          i_cin,
    output logic [SW-1:0] o_sum,
    output logic          o_cout
);

    logic       w_carry;
    logic [1:0] w_fa;

    // Ripple the carry through the slice one full adder at a time.
    always_comb begin
        w_carry = i_cin;
        w_fa    = 2'b00;
        o_sum   = '0;
        for (int i = 0; i < SW; i++) begin
            w_fa     = pa_full_add(i_a[i], i_b[i], w_carry);
            o_sum[i] = w_fa[0];
            w_carry  = w_fa[1];
        end
        o_cout = w_carry;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry adder: input register plus STAGES carry-chain slices.
// Define PIPE_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = PA_WIDTH_DEF,
    parameter int STAGES = PA_STAGES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             valid_out,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW     = pa_cfg_ok(WIDTH, STAGES) ? (WIDTH / STAGES) : 1;
    localparam int OP_TOT = SW * ((STAGES * (STAGES + 1)) / 2);
    localparam int SM_TOT = OP_TOT;

    if (!pa_cfg_ok(WIDTH, STAGES)) begin : gen_cfg_err
        $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // Pending operand slices and finished sum slices, one triangle segment per stage.
    logic [OP_TOT-1:0] w_a_tri;
    logic [OP_TOT-1:0] w_b_tri;
    logic [SM_TOT-1:0] w_s_tri;
    logic [STAGES:0]   w_c;
    logic [STAGES:0]   w_v;

    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_b0;
    logic             r_c0;
    logic             r_v0;

    // Stage 0: capture operands, carry-in and the valid tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0 <= '0;
            r_b0 <= '0;
            r_c0 <= 1'b0;
            r_v0 <= 1'b0;
        end else if (en) begin
            r_a0 <= a;
            r_b0 <= b;
            r_c0 <= cin;
            r_v0 <= valid_in;
        end
    end

    assign w_a_tri[WIDTH-1:0] = r_a0;
    assign w_b_tri[WIDTH-1:0] = r_b0;
    assign w_c[0]             = r_c0;
    assign w_v[0]             = r_v0;

`ifdef PIPE_ADDER_OVF_EN
    logic w_ovf;
`endif

    for (genvar k = 1; k <= STAGES; k++) begin : gen_stage
        localparam int IN_OFF = pa_op_off(k - 1, STAGES, SW);
        localparam int SO     = pa_sum_off(k, SW);

        logic [SW-1:0]   w_sl_sum;
        logic            w_sl_co;
        logic [k*SW-1:0] w_sum_nxt;
        logic [k*SW-1:0] r_sum;
        logic            r_c;
        logic            r_v;

        adder_slice #(.SW(SW)) u_slice (
            .i_a   (w_a_tri[IN_OFF +: SW]),
            .i_b   (w_b_tri[IN_OFF +: SW]),
            .i_cin (w_c[k-1]),
            .o_sum (w_sl_sum),
            .o_cout(w_sl_co)
        );

        if (k == 1) begin : gen_first
            assign w_sum_nxt = w_sl_sum;
        end else begin : gen_rest
            assign w_sum_nxt = {w_sl_sum, w_s_tri[pa_sum_off(k - 1, SW) +: (k - 1) * SW]};
        end

        // Register this slice's partial sum alongside the lower slices already done.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sum <= '0;
                r_c   <= 1'b0;
                r_v   <= 1'b0;
            end else if (en) begin
                r_sum <= w_sum_nxt;
                r_c   <= w_sl_co;
                r_v   <= w_v[k-1];
            end
        end

        assign w_s_tri[SO +: k*SW] = r_sum;
        assign w_c[k]              = r_c;
        assign w_v[k]              = r_v;

        if (k < STAGES) begin : gen_fwd
            localparam int OUT_OFF = pa_op_off(k, STAGES, SW);
            localparam int FW      = (STAGES - k) * SW;

            logic [FW-1:0] r_a_hi;
            logic [FW-1:0] r_b_hi;

            // Skew the not-yet-added upper operand slices one stage forward.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= '0;
                    r_b_hi <= '0;
                end else if (en) begin
                    r_a_hi <= w_a_tri[IN_OFF + SW +: FW];
                    r_b_hi <= w_b_tri[IN_OFF + SW +: FW];
                end
            end

            assign w_a_tri[OUT_OFF +: FW] = r_a_hi;
            assign w_b_tri[OUT_OFF +: FW] = r_b_hi;
        end

`ifdef PIPE_ADDER_OVF_EN
        if (k == STAGES) begin : gen_ovf
            logic r_ovf;

            // Carry into the MSB is a^b^sum at that bit; compare it with the carry out.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (en) begin
                    r_ovf <= w_a_tri[IN_OFF + SW - 1] ^ w_b_tri[IN_OFF + SW - 1]
                           ^ w_sl_sum[SW-1] ^ w_sl_co;
                end
            end

            assign w_ovf = r_ovf;
        end
`endif
    end

    assign sum       = w_s_tri[pa_sum_off(STAGES, SW) +: WIDTH];
    assign cout      = w_c[STAGES];
    assign valid_out = w_v[STAGES];
`ifdef PIPE_ADDER_OVF_EN
    assign ovf       = w_ovf;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: 8-bit/2-stage main instance plus 4-bit 1- and 4-stage builds.
module tb_pipe_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, valid_in, cin;
    logic [7:0] a, b;
    logic       valid_out, cout, ovf;
    logic [7:0] sum;

    logic       vin4, cin4;
    logic [3:0] a4, b4;
    logic       v1, c1, o1, v4, c4, o4;
    logic [3:0] s1, s4;

    int n_chk = 0;
    int n_err = 0;
    int ecnt  = 0;
    int e4cnt = 0;

    // Expected result keyed by the enabled-edge count at which it must be on the outputs.
    int exp_m [int];
    int exp1  [int];
    int exp4  [int];

    always #5 clk = ~clk;

    pipe_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .valid_in(valid_in),
        .a(a), .b(b), .cin(cin),
        .valid_out(valid_out), .sum(sum), .cout(cout)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(ovf)
`endif
    );

    pipe_adder #(.WIDTH(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .valid_in(vin4),
        .a(a4), .b(b4), .cin(cin4),
        .valid_out(v1), .sum(s1), .cout(c1)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(o1)
`endif
    );

    pipe_adder #(.WIDTH(4), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .valid_in(vin4),
        .a(a4), .b(b4), .cin(cin4),
        .valid_out(v4), .sum(s4), .cout(c4)
`ifdef PIPE_ADDER_OVF_EN
        , .ovf(o4)
`endif
    );

`ifndef PIPE_ADDER_OVF_EN
    assign ovf = 1'b0;
    assign o1  = 1'b0;
    assign o4  = 1'b0;
`endif

    // Reference: bit w+1 = signed overflow, bits w..0 = a + b + cin.
    function automatic int ref_add(input int w, input int x, input int y, input int c);
        int s, sx, sy, ss, lim;
        bit o;
        lim = 1 << (w - 1);
        s   = x + y + c;
        sx  = (x >= lim) ? x - (1 << w) : x;
        sy  = (y >= lim) ? y - (1 << w) : y;
        ss  = sx + sy + c;
        o   = (ss > lim - 1) || (ss < -lim);
        return (int'(o) << (w + 1)) | s;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_res(input string tag, input bit present, input int expv, input int w,
                           input logic vo, input logic [8:0] res, input logic o);
        if (present) begin
            chk({tag, "_valid"}, {31'd0, vo}, 32'd1);
            chk({tag, "_sum"}, {23'd0, res}, expv & ((1 << (w + 1)) - 1));
`ifdef PIPE_ADDER_OVF_EN
            chk({tag, "_ovf"}, {31'd0, o}, (expv >> (w + 1)) & 1);
`endif
        end else begin
            chk({tag, "_idle"}, {31'd0, vo}, 32'd0);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [7:0] x, input logic [7:0] y,
                        input logic c);
        en = e; valid_in = v; a = x; b = y; cin = c;
        @(posedge clk); #1;
        if (e) begin
            ecnt++;
            if (v) exp_m[ecnt + 2] = ref_add(8, int'(x), int'(y), int'(c));
        end
        chk_res("main", exp_m.exists(ecnt), exp_m.exists(ecnt) ? exp_m[ecnt] : 0, 8,
                valid_out, {cout, sum}, ovf);
    endtask

    task automatic step4(input logic v, input logic [3:0] x, input logic [3:0] y, input logic c);
        vin4 = v; a4 = x; b4 = y; cin4 = c;
        @(posedge clk); #1;
        e4cnt++;
        if (v) begin
            exp1[e4cnt + 1] = ref_add(4, int'(x), int'(y), int'(c));
            exp4[e4cnt + 4] = ref_add(4, int'(x), int'(y), int'(c));
        end
        chk_res("s1", exp1.exists(e4cnt), exp1.exists(e4cnt) ? exp1[e4cnt] : 0, 4,
                v1, {4'd0, c1, s1}, o1);
        chk_res("s4", exp4.exists(e4cnt), exp4.exists(e4cnt) ? exp4[e4cnt] : 0, 4,
                v4, {4'd0, c4, s4}, o4);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; valid_in = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        vin4 = 1'b0; a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_sum", {23'd0, cout, sum}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single operations, including carry wrap and signed overflow.
        step(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
        step(1'b1, 1'b1, 8'h7F, 8'h01, 1'b0);
        step(1'b1, 1'b1, 8'h80, 8'h80, 1'b0);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Back-to-back random stream.
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Stall mid-stream; offered inputs during en=0 must be dropped.
        for (int i = 0; i < 12; i++) begin
            if (i >= 5 && i < 8) step(1'b0, 1'b1, 8'hAA, 8'h55, 1'b1);
            else step(1'b1, 1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
        end
        repeat (4) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Mixed valid/en pattern.
        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom));
        repeat (4) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Asynchronous reset with two operations in flight.
        step(1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
        step(1'b1, 1'b1, 8'hF0, 8'h0F, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid_out}, 32'd0);
        chk("arst_sum", {23'd0, cout, sum}, 32'd0);
        exp_m.delete();
        en = 1'b1; valid_in = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (4) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'hC3, 8'h3C, 1'b1);
        repeat (3) step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

        // Exhaustive 4-bit operands on the single-stage and fully pipelined builds.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                for (int c = 0; c < 2; c++)
                    step4(1'b1, 4'(x), 4'(y), 1'(c));
        repeat (6) step4(1'b0, 4'h0, 4'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined ripple-carry adder: the next generation of the single-bit registered full adder. It adds two WIDTH-bit operands plus carry-in, splitting the carry chain into STAGES equal slices with one register per slice. Each operation travels with a valid bit, and a global enable freezes the whole pipeline. It serves as the arithmetic datapath building block for wider accumulators and counters in the design.

## Interface
- WIDTH, 8, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 2, number of carry-chain slices (pipeline stages after the input register); 1..WIDTH.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  pipeline enable; 0 freezes every register.
- valid_in  input  1  operands on a/b/cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- valid_out  output  1  sum/cout hold a valid result.
- sum  output  WIDTH  registered result bits.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  signed overflow; present only with PIPE_ADDER_OVF_EN.

## Operation
- Slice width is SW = WIDTH/STAGES. Slice k covers bits [k*SW +: SW].
- Input register (stage 0) captures a, b, cin and valid_in when en=1.
- Stage k (1..STAGES):
  - Adds slice k-1 of the delayed operands with the carry from stage k-1.
  - Registers the partial sum and carry-out.
  - Carries forward the still-unused upper operand slices, skew-aligned.
  - Carries forward the already-computed lower sum slices.
- Stage STAGES drives sum, cout and valid_out directly.
- Result: {cout, sum} = a + b + cin, exact modulo 2^(WIDTH+1). No saturation.
- valid is a pure tag:
  - Data registers load on every enabled edge regardless of valid_in.
  - sum/cout are defined only while valid_out=1.
- en=0 holds all data and valid registers; inputs are ignored that cycle.
- No backpressure. The consumer must accept a result whenever valid_out=1 and en=1.

## Timing
- Latency is STAGES+1 enabled rising edges from sampling to valid_out=1.
  - STAGES=1 gives latency 2, matching the registered-in/registered-out full adder.
- Throughput is one operation per enabled cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Stall: each en=0 cycle adds exactly one cycle of latency to every in-flight operation. No operation is lost or duplicated.
- Reset:
  - rst_n=0 asynchronously clears all registers, so sum=0, cout=0, valid_out=0 and ovf=0.
  - In-flight operations are discarded.
- After reset release, the first valid_out appears no earlier than STAGES+1 enabled edges after the first valid_in=1.
- Simultaneous en=0 and valid_in=1: the input is not captured; the source must hold or re-present it.

## Configuration
- PIPE_ADDER_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, registered and aligned with sum.
  - ovf resets to 0.
- PIPE_ADDER_OVF_EN undefined: the ovf port and its logic are absent. All other behaviour is identical.

## Structure
- Package pipe_adder_pkg holds:
  - Default parameter constants PA_WIDTH_DEF=8 and PA_STAGES_DEF=2.
  - A function that checks WIDTH % STAGES == 0. An elaboration-time error fires if the check fails.
- Sub-module adder_slice: SW-bit combinational ripple adder with carry-in/carry-out, built from gate-level full adders. It is instantiated once per stage via generate.

## Test plan
- WIDTH=8, STAGES=2, en=1, single op a=0x0F, b=0x01, cin=0 -> after 3 edges valid_out=1, sum=0x10, cout=0.
- Wrap: a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1. With OVF_EN, a=0x7F, b=0x01 -> ovf=1 and sum=0x80.
- Streaming: 20 random back-to-back ops -> 20 consecutive valid results in order, each equal to the reference sum.
- Stall: en=0 for 3 cycles mid-stream -> all outputs frozen, and results resume unchanged with latency +3.
- Reset mid-operation: pull rst_n low with two ops in flight -> sum=0, cout=0 and valid_out=0 immediately; no stale valid after release.
- STAGES=1 and STAGES=WIDTH=4 builds: exhaustive a, b, cin -> all results correct, with latency 2 and 5 respectively.
